// File: rtl/tdc_therm_dec.sv
// Thermometer-to-binary decoder for the TDC carry-chain snapshot.
// Four register stages: capture, bubble correction, group popcount, final sum.
module tdc_therm_dec #(
  parameter int R = 1000,
  parameter int G = 20,
  parameter int W = $clog2(R + 1)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  input  logic [R-1:0] i_therm,
  output logic         o_valid,
  output logic [W-1:0] o_code,
  output logic         o_zero,
  output logic         o_ovf,
  output logic         o_bubble
);

  localparam int N  = R / G;
  localparam int PW = $clog2(G + 1);

  function automatic logic [R-1:0] maj3(input logic [R-1:0] a, input logic [R-1:0] b,
                                        input logic [R-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic [R-1:0]  therm_r;
  logic          v1_r;
  logic [R+1:0]  ext_s;
  logic [R-1:0]  corr_s;
  logic          bub_s;
  logic [R-1:0]  corr_r;
  logic          bub2_r;
  logic          v2_r;
  logic [PW-1:0] part_s [N];
  logic          zero_s;
  logic          ovf_s;
  logic [PW-1:0] part_r [N];
  logic          zero3_r;
  logic          ovf3_r;
  logic          bub3_r;
  logic          v3_r;
  logic [W-1:0]  sum_s;

  // Stage 1: capture the raw snapshot
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      therm_r <= {R{1'b0}};
      v1_r    <= 1'b0;
    end else begin
      v1_r <= i_valid;
      if (i_valid) therm_r <= i_therm;
    end
  end

  // Majority-of-three correction; chain entry sees a virtual 1 below, a virtual 0 above
  always_comb begin
    ext_s  = {1'b0, therm_r, 1'b1};
    corr_s = maj3(ext_s[R-1:0], ext_s[R:1], ext_s[R+1:2]);
    bub_s  = |(corr_s ^ therm_r);
  end

  // Stage 2: register corrected vector and bubble flag
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      corr_r <= {R{1'b0}};
      bub2_r <= 1'b0;
      v2_r   <= 1'b0;
    end else begin
      v2_r <= v1_r;
      if (v1_r) begin
        corr_r <= corr_s;
        bub2_r <= bub_s;
      end
    end
  end

  // Group popcounts plus all-zero / all-one detection
  always_comb begin
    for (int g = 0; g < N; g++) begin
      part_s[g] = {PW{1'b0}};
      for (int b = 0; b < G; b++) begin
        part_s[g] = part_s[g] + {{(PW-1){1'b0}}, corr_r[g*G+b]};
      end
    end
    zero_s = ~|corr_r;
    ovf_s  = &corr_r;
  end

  // Stage 3: register partial counts and flags
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int g = 0; g < N; g++) part_r[g] <= {PW{1'b0}};
      zero3_r <= 1'b0;
      ovf3_r  <= 1'b0;
      bub3_r  <= 1'b0;
      v3_r    <= 1'b0;
    end else begin
      v3_r <= v2_r;
      if (v2_r) begin
        for (int g = 0; g < N; g++) part_r[g] <= part_s[g];
        zero3_r <= zero_s;
        ovf3_r  <= ovf_s;
        bub3_r  <= bub2_r;
      end
    end
  end

  // Final sum of partials, zero-extended so R itself fits
  always_comb begin
    sum_s = {W{1'b0}};
    for (int g = 0; g < N; g++) begin
      sum_s = sum_s + {{(W-PW){1'b0}}, part_r[g]};
    end
  end

  // Stage 4: registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid  <= 1'b0;
      o_code   <= {W{1'b0}};
      o_zero   <= 1'b0;
      o_ovf    <= 1'b0;
      o_bubble <= 1'b0;
    end else begin
      o_valid <= v3_r;
      if (v3_r) begin
        o_code   <= sum_s;
        o_zero   <= zero3_r;
        o_ovf    <= ovf3_r;
        o_bubble <= bub3_r;
      end
    end
  end

endmodule

// File: tb/tb_tdc_therm_dec.sv
// Directed and randomized checks for tdc_therm_dec (R=1000, G=20).
module tb_tdc_therm_dec;
  localparam int R = 1000;
  localparam int G = 20;
  localparam int W = 11;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         valid = 1'b0;
  logic [R-1:0] therm = '0;
  logic         o_valid;
  logic [W-1:0] o_code;
  logic         o_zero, o_ovf, o_bubble;

  int checks = 0;
  int failures = 0;
  int nxt_c = 0;
  bit nxt_b = 1'b0;
  bit pv [4];
  int pc [4];
  bit pb [4];

  logic [R-1:0] t;
  int fp [3];
  int nf, kf, n, p;
  bit ok;

  tdc_therm_dec #(.R(R), .G(G), .W(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_therm(therm),
    .o_valid(o_valid), .o_code(o_code), .o_zero(o_zero), .o_ovf(o_ovf), .o_bubble(o_bubble)
  );

  always #5 clk = ~clk;

  function automatic logic [R-1:0] therm_of(input int cnt);
    logic [R-1:0] v;
    v = '0;
    for (int i = 0; i < cnt; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(o_valid), 32'd0);
    chk({tag, "_code"}, 32'(o_code), 32'd0);
    chk({tag, "_zero"}, 32'(o_zero), 32'd0);
    chk({tag, "_ovf"}, 32'(o_ovf), 32'd0);
    chk({tag, "_bubble"}, 32'(o_bubble), 32'd0);
  endtask

  // One clock: advance the expectation pipeline and check the outputs
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 3; i > 0; i--) begin
      pv[i] = pv[i-1]; pc[i] = pc[i-1]; pb[i] = pb[i-1];
    end
    pv[0] = valid; pc[0] = nxt_c; pb[0] = nxt_b;
    if (rst) begin
      for (int i = 0; i < 4; i++) pv[i] = 1'b0;
      chk_reset_outputs("reset");
    end else begin
      chk("o_valid", 32'(o_valid), 32'(pv[3]));
      if (pv[3]) begin
        chk("o_code", 32'(o_code), 32'(pc[3]));
        chk("o_zero", 32'(o_zero), 32'(pc[3] == 0));
        chk("o_ovf", 32'(o_ovf), 32'(pc[3] == R));
        chk("o_bubble", 32'(o_bubble), 32'(pb[3]));
      end
    end
  endtask

  task automatic drive(input logic v, input logic [R-1:0] tv, input int code, input bit bub);
    valid = v; therm = tv; nxt_c = code; nxt_b = bub;
    tick();
    valid = 1'b0; nxt_c = 0; nxt_b = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) tick();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin pv[i] = 1'b0; pc[i] = 0; pb[i] = 1'b0; end

    // Reset held for three cycles, then a single 437 sample
    idle(3);
    rst = 1'b0;
    idle(2);
    drive(1'b1, therm_of(437), 437, 1'b0);
    idle(6);

    // Bounds
    drive(1'b1, therm_of(0), 0, 1'b0);
    drive(1'b1, therm_of(R), R, 1'b0);
    drive(1'b1, therm_of(1), 1, 1'b0);
    drive(1'b1, therm_of(999), 999, 1'b0);

    // Bubbles
    t = therm_of(200); t[205] = 1'b1;
    drive(1'b1, t, 200, 1'b1);
    t = therm_of(200); t[150] = 1'b0;
    drive(1'b1, t, 200, 1'b1);
    drive(1'b1, therm_of(201), 201, 1'b0);
    idle(5);

    // Back-to-back throughput
    drive(1'b1, therm_of(0), 0, 1'b0);
    drive(1'b1, therm_of(1), 1, 1'b0);
    drive(1'b1, therm_of(2), 2, 1'b0);
    drive(1'b1, therm_of(500), 500, 1'b0);
    drive(1'b1, therm_of(998), 998, 1'b0);
    drive(1'b1, therm_of(999), 999, 1'b0);
    drive(1'b1, therm_of(R), R, 1'b0);
    drive(1'b1, therm_of(3), 3, 1'b0);
    drive(1'b1, therm_of(77), 77, 1'b0);
    drive(1'b0, therm_of(12), 0, 1'b0);
    drive(1'b0, therm_of(13), 0, 1'b0);
    drive(1'b1, therm_of(640), 640, 1'b0);
    idle(5);

    // Reset mid-stream discards in-flight samples
    drive(1'b1, therm_of(10), 10, 1'b0);
    drive(1'b1, therm_of(20), 20, 1'b0);
    drive(1'b1, therm_of(30), 30, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    for (int i = 0; i < 4; i++) pv[i] = 1'b0;
    tick();
    rst = 1'b0;
    idle(1);
    drive(1'b1, therm_of(64), 64, 1'b0);
    idle(6);

    // Random codes with isolated, well-separated bubbles
    repeat (10000) begin
      kf = $urandom_range(0, 9);
      if (kf == 0) n = 0;
      else if (kf == 1) n = R;
      else n = $urandom_range(0, R);
      t = therm_of(n);
      kf = $urandom_range(0, 3);
      nf = 0;
      for (int a = 0; a < 20 && nf < kf; a++) begin
        p = $urandom_range(0, R - 1);
        ok = (p + 2 < n) || (p - 2 >= n);
        for (int j = 0; j < nf; j++) if (p - fp[j] < 3 && fp[j] - p < 3) ok = 1'b0;
        if (ok) begin
          t[p] = ~t[p];
          fp[nf] = p;
          nf++;
        end
      end
      drive(($urandom_range(0, 3) != 0), t, n, (nf > 0));
    end
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
